// File: rtl/my_loop_pkg.sv
// Shared types and helpers for the gyro step/ramp feedback stage.
package my_loop_pkg;

  typedef enum logic [1:0] {
    OPEN       = 2'd0,
    CLOSE_INIT = 2'd1,
    CLOSED     = 2'd2
  } loop_state_t;

  localparam int STEP_W = 32;

  // Clamp a 33-bit signed value to [-lim, +lim]; lim is assumed positive.
  function automatic logic signed [31:0] sat_32(input logic signed [32:0] val,
                                                input logic signed [31:0] lim);
    logic signed [32:0] lim_p;
    logic signed [32:0] lim_n;
    lim_p = {lim[31], lim};
    lim_n = -lim_p;
    if (val > lim_p)
      return lim;
    else if (val < lim_n)
      return lim_n[31:0];
    else
      return val[31:0];
  endfunction

endpackage

// File: rtl/my_ramp_acc.sv
// 32-bit modular phase accumulator with signed increment and 2*pi wrap flag.
module my_ramp_acc
  import my_loop_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [STEP_W-1:0] inc,
  output logic [STEP_W-1:0]        acc,
  output logic                     wrap
);

  logic [STEP_W:0] sum;
  logic            wrap_nxt;

  assign sum = {1'b0, acc} + {1'b0, inc};
  // Negative increments appear as large unsigned adds: no carry means a borrow.
  assign wrap_nxt = inc[STEP_W-1] ? ~sum[STEP_W] : sum[STEP_W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      acc  <= '0;
      wrap <= 1'b0;
    end else if (en) begin
      acc  <= sum[STEP_W-1:0];
      wrap <= wrap_nxt;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/my_step_ramp_gen_v1.sv
// Closed-loop step integrator, rate latch and phase ramp driving the modulator DAC.
//   state      | meaning
//   OPEN       | step follows i_const_step (saturated)
//   CLOSE_INIT | one cycle; clears step and ramp, sync pulses ignored
//   CLOSED     | step integrates i_err >>> i_gain_sel (saturated)
module my_step_ramp_gen_v1
  import my_loop_pkg::*;
#(
  parameter int DAC_BIT = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_loop_en,
  input  logic                      i_step_sync,
  input  logic                      i_rate_sync,
  input  logic                      i_ramp_sync,
  input  logic signed [31:0]        i_err,
  input  logic [4:0]                i_gain_sel,
  input  logic signed [31:0]        i_step_max,
  input  logic signed [31:0]        i_const_step,
  input  logic                      i_status,
  input  logic signed [DAC_BIT-1:0] i_mod_high,
  input  logic signed [DAC_BIT-1:0] i_mod_low,
  output logic signed [31:0]        o_step,
  output logic signed [31:0]        o_rate,
  output logic                      o_rate_valid,
  output logic [31:0]               o_ramp,
  output logic                      o_wrap,
  output logic [DAC_BIT-1:0]        o_dac,
  output logic [1:0]                o_loop_state
);

  loop_state_t              state;
  loop_state_t              state_nxt;
  logic signed [31:0]       err_sh;
  logic signed [32:0]       step_sum;
  logic signed [31:0]       step_nxt;
  logic                     init_clr;
  logic [DAC_BIT-1:0]       mod_sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= OPEN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = OPEN;
    case (state)
      OPEN:       state_nxt = i_loop_en ? CLOSE_INIT : OPEN;
      CLOSE_INIT: state_nxt = CLOSED;
      CLOSED:     state_nxt = i_loop_en ? CLOSED : OPEN;
      default:    state_nxt = OPEN;
    endcase
  end

  assign init_clr     = (state == CLOSE_INIT);
  assign o_loop_state = state;

  assign err_sh   = i_err >>> i_gain_sel;
  assign step_sum = {o_step[31], o_step} + {err_sh[31], err_sh};

  always_comb begin
    step_nxt = o_step;
    if (init_clr)
      step_nxt = '0;
    else if (i_step_sync) begin
      if (state == CLOSED)
        step_nxt = sat_32(step_sum, i_step_max);
      else
        step_nxt = sat_32({i_const_step[31], i_const_step}, i_step_max);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_step       <= '0;
      o_rate       <= '0;
      o_rate_valid <= 1'b0;
    end else begin
      o_step       <= step_nxt;
      o_rate_valid <= i_rate_sync;
      if (i_rate_sync) o_rate <= o_step;
    end
  end

  // Ramp advances with the pre-update step so same-cycle syncs see the old value.
  my_ramp_acc u_ramp_acc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr     (init_clr),
    .en      (i_ramp_sync),
    .inc     (o_step),
    .acc     (o_ramp),
    .wrap    (o_wrap)
  );

  assign mod_sel = i_status ? i_mod_high : i_mod_low;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_dac <= '0;
    else          o_dac <= o_ramp[31 -: DAC_BIT] + mod_sel;
  end

endmodule

// File: tb/tb_my_step_ramp_gen_v1.sv
// Directed bench with an arithmetic reference model for my_step_ramp_gen_v1.
module tb_my_step_ramp_gen_v1;

  logic               i_clk = 1'b0;
  logic               i_rst_n = 1'b1;
  logic               i_loop_en = 1'b0;
  logic               i_step_sync = 1'b0;
  logic               i_rate_sync = 1'b0;
  logic               i_ramp_sync = 1'b0;
  logic signed [31:0] i_err = '0;
  logic [4:0]         i_gain_sel = '0;
  logic signed [31:0] i_step_max = '0;
  logic signed [31:0] i_const_step = '0;
  logic               i_status = 1'b0;
  logic signed [15:0] i_mod_high = '0;
  logic signed [15:0] i_mod_low = '0;
  logic signed [31:0] o_step;
  logic signed [31:0] o_rate;
  logic               o_rate_valid;
  logic [31:0]        o_ramp;
  logic               o_wrap;
  logic [15:0]        o_dac;
  logic [1:0]         o_loop_state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  my_step_ramp_gen_v1 #(.DAC_BIT(16)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_loop_en    (i_loop_en),
    .i_step_sync  (i_step_sync),
    .i_rate_sync  (i_rate_sync),
    .i_ramp_sync  (i_ramp_sync),
    .i_err        (i_err),
    .i_gain_sel   (i_gain_sel),
    .i_step_max   (i_step_max),
    .i_const_step (i_const_step),
    .i_status     (i_status),
    .i_mod_high   (i_mod_high),
    .i_mod_low    (i_mod_low),
    .o_step       (o_step),
    .o_rate       (o_rate),
    .o_rate_valid (o_rate_valid),
    .o_ramp       (o_ramp),
    .o_wrap       (o_wrap),
    .o_dac        (o_dac),
    .o_loop_state (o_loop_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the documented rules.
  localparam longint TWO32 = 64'sh1_0000_0000;
  int     m_state = 0;
  longint m_step = 0, m_rate = 0, m_ramp = 0;
  bit     m_rv = 0, m_wrap = 0;
  int     m_dac = 0;

  always @(posedge i_clk or negedge i_rst_n) begin
    int     n_state, mod;
    longint n_step, n_ramp, s, lim;
    bit     n_wrap;
    if (!i_rst_n) begin
      m_state <= 0; m_step <= 0; m_rate <= 0; m_rv <= 0;
      m_ramp <= 0; m_wrap <= 0; m_dac <= 0;
    end else begin
      mod = i_status ? int'(i_mod_high) : int'(i_mod_low);
      lim = longint'(i_step_max);
      n_step = m_step;
      n_ramp = m_ramp;
      n_wrap = 1'b0;
      if (m_state == 1) begin
        n_step = 0;
        n_ramp = 0;
      end else begin
        if (i_step_sync) begin
          s = (m_state == 2) ? m_step + (longint'(i_err) >>> i_gain_sel) : longint'(i_const_step);
          if (s > lim) s = lim;
          else if (s < -lim) s = -lim;
          n_step = s;
        end
        if (i_ramp_sync) begin
          s = m_ramp + m_step;
          n_wrap = (s >= TWO32) || (s < 0);
          if (s >= TWO32) s = s - TWO32;
          if (s < 0) s = s + TWO32;
          n_ramp = s;
        end
      end
      case (m_state)
        0: n_state = i_loop_en ? 1 : 0;
        1: n_state = 2;
        default: n_state = i_loop_en ? 2 : 0;
      endcase
      if (i_rate_sync) m_rate <= m_step;
      m_rv    <= i_rate_sync;
      m_dac   <= (int'(m_ramp / 65536) + mod) & 32'hFFFF;
      m_step  <= n_step;
      m_ramp  <= n_ramp;
      m_wrap  <= n_wrap;
      m_state <= n_state;
    end
  end

  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("m_step",  o_step, 32'(m_step));
      chk("m_rate",  o_rate, 32'(m_rate));
      chk("m_rv",    {31'd0, o_rate_valid}, {31'd0, m_rv});
      chk("m_ramp",  o_ramp, 32'(m_ramp));
      chk("m_wrap",  {31'd0, o_wrap}, {31'd0, m_wrap});
      chk("m_dac",   {16'd0, o_dac}, 32'(m_dac));
      chk("m_state", {30'd0, o_loop_state}, 32'(m_state));
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_step(input logic signed [31:0] err_v);
    i_err = err_v;
    i_step_sync = 1'b1;
    cyc();
    i_step_sync = 1'b0;
  endtask

  task automatic do_ramp();
    i_ramp_sync = 1'b1;
    cyc();
    i_ramp_sync = 1'b0;
  endtask

  initial begin
    #1 i_rst_n = 1'b0;
    i_loop_en = 1'b1; i_err = 32'h100; i_gain_sel = 5'd4; i_step_max = 1000;
    cyc(); cyc();
    cmp_en = 1'b1;
    chk("rst_step", o_step, 0);
    chk("rst_ramp", o_ramp, 0);
    chk("rst_dac", {16'd0, o_dac}, 0);
    chk("rst_state", {30'd0, o_loop_state}, 0);
    i_rst_n = 1'b1;
    cyc(); cyc();
    chk("closed_state", {30'd0, o_loop_state}, 2);

    i_step_sync = 1'b1;
    cyc(); chk("int_16", o_step, 16);
    cyc(); chk("int_32", o_step, 32);
    cyc(); chk("int_48", o_step, 48);
    i_step_sync = 1'b0;
    i_rate_sync = 1'b1;
    cyc(); chk("rate_48", o_rate, 48); chk("rate_valid", {31'd0, o_rate_valid}, 1);
    i_rate_sync = 1'b0;
    cyc(); chk("rate_valid_drop", {31'd0, o_rate_valid}, 0);

    i_gain_sel = 5'd0;
    do_step(942);     chk("step_990", o_step, 990);
    do_step(32'h1000); chk("sat_pos", o_step, 1000);
    do_step(-5000);   chk("sat_neg", o_step, 32'hFFFF_FC18);

    do_step(984);
    do_ramp(); chk("ramp_fff0", o_ramp, 32'hFFFF_FFF0); chk("wrap_borrow0", {31'd0, o_wrap}, 1);
    do_step(48);
    do_ramp(); chk("ramp_10", o_ramp, 32'h10); chk("wrap_carry", {31'd0, o_wrap}, 1);
    do_step(-64);
    do_ramp(); chk("ramp_back", o_ramp, 32'hFFFF_FFF0); chk("wrap_borrow", {31'd0, o_wrap}, 1);
    do_step(32);
    do_ramp(); chk("ramp_zero_step", o_ramp, 32'hFFFF_FFF0); chk("wrap_zero", {31'd0, o_wrap}, 0);

    i_err = 100; i_step_sync = 1'b1; i_rate_sync = 1'b1; i_ramp_sync = 1'b1;
    cyc();
    i_step_sync = 1'b0; i_rate_sync = 1'b0; i_ramp_sync = 1'b0;
    chk("conc_step", o_step, 100); chk("conc_rate", o_rate, 0); chk("conc_ramp", o_ramp, 32'hFFFF_FFF0);
    i_ramp_sync = 1'b1; cyc(); cyc(); i_ramp_sync = 1'b0;
    chk("long_pulse", o_ramp, 32'hB8);

    i_loop_en = 1'b0; cyc(); chk("to_open", {30'd0, o_loop_state}, 0);
    i_loop_en = 1'b1; cyc();
    i_loop_en = 1'b0; cyc();
    chk("init_step", o_step, 0); chk("init_ramp", o_ramp, 0);
    cyc();
    i_const_step = 5;
    for (int k = 0; k < 4; k++) begin
      do_step(32'h12345);
      do_ramp();
    end
    chk("open_ramp", o_ramp, 20); chk("open_step", o_step, 5);
    i_loop_en = 1'b1; cyc(); cyc();
    chk("rise_step", o_step, 0); chk("rise_ramp", o_ramp, 0);

    i_loop_en = 1'b0; cyc();
    i_const_step = -2000; do_step(0);
    chk("open_sat", o_step, 32'hFFFF_FC18);
    i_step_max = 32'h7FFF_FFFF; i_const_step = 32'h4000_0000;
    do_step(0); do_ramp(); do_ramp();
    chk("ramp_half", o_ramp, 32'h8000_0000);
    i_mod_high = 16'sh1000; i_mod_low = -16'sh1000; i_status = 1'b1;
    cyc(); chk("dac_hi", {16'd0, o_dac}, 32'h9000);
    i_status = 1'b0;
    cyc(); chk("dac_lo", {16'd0, o_dac}, 32'h7000);
    i_status = 1'b1;
    cyc(); chk("dac_hi2", {16'd0, o_dac}, 32'h9000);

    i_const_step = 7; do_step(0);
    i_rate_sync = 1'b1; cyc(); i_rate_sync = 1'b0;
    i_rst_n = 1'b0; #1;
    chk("mid_rst_step", o_step, 0); chk("mid_rst_rate", o_rate, 0);
    chk("mid_rst_ramp", o_ramp, 0); chk("mid_rst_dac", {16'd0, o_dac}, 0);
    cyc();
    i_rst_n = 1'b1;
    do_ramp();
    chk("post_rst_ramp", o_ramp, 0); chk("post_rst_wrap", {31'd0, o_wrap}, 0);
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_step_ramp_gen_v1.md
# my_step_ramp_gen_v1

Closed-loop feedback stage directly downstream of the demodulating error-signal generator in the HINS fibre-optic gyro chain. It integrates the per-cycle error word into a saturated step value (rate estimate), publishes the rate, and accumulates the step into a 32-bit phase ramp that wraps at 2π. The modulator's square-wave level is added on top to form the phase-modulator DAC word. Step, rate and ramp updates are sequenced by the upstream one-cycle sync pulses.

## Interface
- DAC_BIT, 16, width of DAC output and modulation levels
- i_clk  in  1  system clock
- i_rst_n  in  1  reset; asynchronous, active-low; clock i_clk
- i_loop_en  in  1  level; 1 = closed loop, 0 = open loop
- i_step_sync  in  1  one-cycle pulse; new i_err valid
- i_rate_sync  in  1  one-cycle pulse; publish rate
- i_ramp_sync  in  1  one-cycle pulse; advance ramp
- i_err  in  32 signed  demodulated error word
- i_gain_sel  in  5  integrator gain as right-shift count, 0..31
- i_step_max  in  32 signed  saturation magnitude, positive; step clamped to ±i_step_max
- i_const_step  in  32 signed  open-loop step value
- i_status  in  1  modulation half: 1 = high, 0 = low
- i_mod_high, i_mod_low  in  DAC_BIT signed  modulation levels
- o_step  out  32 signed  current step
- o_rate  out  32 signed  latched rate
- o_rate_valid  out  1  one-cycle pulse with each new o_rate
- o_ramp  out  32  phase ramp accumulator, unsigned modulo 2^32
- o_wrap  out  1  one-cycle pulse on ramp wrap
- o_dac  out  DAC_BIT  modulator DAC word
- o_loop_state  out  2  FSM state, for debug

## Operation
- FSM states: OPEN=0, CLOSE_INIT=1, CLOSED=2.
  - OPEN→CLOSE_INIT when i_loop_en=1.
  - CLOSE_INIT→CLOSED unconditionally after one cycle; this cycle clears step and ramp to 0.
  - CLOSED→OPEN when i_loop_en=0.
  - Encodings 3 and above → OPEN.
- Step update, on i_step_sync:
  - CLOSED: step ← sat(step + (i_err >>> i_gain_sel)). The sum is formed at 33 bits, then clamped to [−i_step_max, +i_step_max].
  - OPEN: step ← sat(i_const_step).
  - CLOSE_INIT: the pulse is ignored; the clear wins.
- Rate, on i_rate_sync: o_rate ← step; o_rate_valid=1 for that cycle. Behaviour is identical in all states.
- Ramp, on i_ramp_sync (except in CLOSE_INIT): ramp ← ramp + step, modulo 2^32.
  - o_wrap=1 when the unsigned add carries out with step ≥ 0.
  - o_wrap=1 when the add borrows with step < 0.
  - o_wrap=0 when step = 0.
- DAC, every cycle: o_dac ← ramp[31 -: DAC_BIT] + (i_status ? i_mod_high : i_mod_low), modulo 2^DAC_BIT.
- Simultaneous events:
  - Concurrent syncs use pre-update values: rate and ramp see the old step.
  - i_loop_en toggling mid-sequence takes effect at the next FSM transition only.

## Timing
- Reset values: all outputs 0, state OPEN, internal step and ramp 0.
- Latencies:
  - o_step, o_rate/o_rate_valid, o_ramp/o_wrap: 1 cycle after the respective sync pulse.
  - o_dac: 1 cycle after ramp or i_status changes.
  - Ramp change to o_dac: 2 cycles after i_ramp_sync.
- Nominal upstream order is step, (dly), rate, ramp on consecutive cycles. Therefore rate reflects the freshly updated step, and the ramp advances by the new step.
- Pulses longer than one cycle are treated as repeated events, one per cycle. No edge detection.
- Reset asserted mid-sequence clears everything immediately; no pending pulse survives.

## Structure
- Package my_loop_pkg: loop_state_t enum; sat_32 function (33-bit input, magnitude limit) for shared use.
- One sub-module, my_ramp_acc: 32-bit modular accumulator with signed increment, wrap detection, synchronous clear and enable. Single-cycle.

## Test plan
- Reset with loop closed, i_err=0x100, i_gain_sel=4, i_step_max=1000; 3 step_sync pulses → o_step = 16, 32, 48; o_rate after next rate_sync = 48.
- Saturation: step=990, i_err=0x1000, gain_sel=0, max=1000 → o_step=1000. Negative i_err=-5000 from 1000 → o_step=-1000.
- Wrap: ramp=0xFFFF_FFF0, step=0x20, ramp_sync → o_ramp=0x10, o_wrap=1. Step=-0x20 from ramp=0x10 → o_ramp=0xFFFF_FFF0, o_wrap=1.
- Open loop: i_loop_en=0, i_const_step=5, 4 step+ramp sequences → o_ramp=20, i_err ignored. Rise of i_loop_en → step and ramp read 0 two cycles later.
- DAC: ramp=0x8000_0000, DAC_BIT=16, i_mod_high=0x1000, i_mod_low=-0x1000; i_status toggle → o_dac alternates 0x9000 / 0x7000 with 1-cycle lag.
- Async reset mid-sequence, between step_sync and ramp_sync → all outputs 0 within the reset; the later ramp_sync after release advances from step 0.
